// File: rtl/com_uart_pkg.sv
// Purpose: shared types and constants for the UART receive-side buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package com_uart_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int RX_FIFO_DEPTH = 8;
  localparam int PERR_CNT_MAX  = 255;

  // One FIFO entry: parity error flag stacked on top of the received byte.
  typedef struct packed {
    logic                  parity_err;
    logic [DATA_WIDTH-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/com_sync_ff.sv
// Purpose: multi-flop synchroniser for a single asynchronous level.
// Latency: STAGES clk cycles from input change to q.
// Backpressure: none; free-running.
//
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, loads RST_VAL into every stage
//   d   - asynchronous input level
//   q   - synchronised level
module com_sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/com_uart_rx_buffer.sv
// Purpose: captures each completed UART frame into a small FWFT FIFO in the clk domain.
// Latency: empty falls SYNC_STAGES+1 clk edges after rx_write_en is seen high.
// Backpressure: none toward the receiver; a frame arriving while full is dropped and flagged.
//
// Ports:
//   clk, rst                      - system clock, synchronous active-high reset
//   rx_write_en                   - receiver write_en (async level, rises at frame end)
//   rx_data, rx_valid_packet      - receiver byte and parity-ok flag, stable around the rise
//   rd_en                         - pop the head entry (ignored when empty)
//   rd_data, rd_parity_err        - head entry, forced to 0 while empty
//   empty, full, count            - occupancy
//   overflow, overflow_clr        - sticky dropped-frame flag and its clear
//   parity_err_cnt                - saturating count of pushed entries with bad parity
module com_uart_rx_buffer #(
  parameter int DEPTH       = com_uart_pkg::RX_FIFO_DEPTH,
  parameter int DATA_WIDTH  = com_uart_pkg::DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_write_en,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid_packet,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_parity_err,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [7:0]               parity_err_cnt
);

  import com_uart_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry layout comes from the package; DATA_WIDTH here must match it.
  rx_entry_t      mem [DEPTH];
  rx_entry_t      head;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  logic sync_out;
  logic edge_reg;
  logic push;
  logic do_push;
  logic do_pop;

  // Synchroniser and edge register reset high: the receiver idles with
  // write_en high, so leaving reset must not look like a rising edge.
  com_sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_wr_en_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_write_en),
    .q   (sync_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_reg <= 1'b1;
    end else begin
      edge_reg <= sync_out;
    end
  end

  assign push = sync_out & ~edge_reg;

  // rx_data / rx_valid_packet are sampled without synchronisation: they are
  // held stable for two baud periods after write_en rises, well past the
  // synchroniser delay.
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= '{parity_err: ~rx_valid_packet, data: rx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      parity_err_cnt <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Set wins over clear.
      if (push && !do_push) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end

      if (do_push && !rx_valid_packet && parity_err_cnt != 8'(PERR_CNT_MAX)) begin
        parity_err_cnt <= parity_err_cnt + 8'd1;
      end
    end
  end

  assign head          = mem[rd_ptr];
  assign rd_data       = empty ? '0 : head.data;
  assign rd_parity_err = empty ? 1'b0 : head.parity_err;

endmodule

// File: tb/tb_com_uart_rx_buffer.sv
module tb_com_uart_rx_buffer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_write_en;
  logic [7:0] rx_data;
  logic       rx_valid_packet;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_parity_err;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       overflow_clr;
  logic [7:0] parity_err_cnt;

  com_uart_rx_buffer #(
    .DEPTH       (DEPTH),
    .DATA_WIDTH  (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_write_en     (rx_write_en),
    .rx_data         (rx_data),
    .rx_valid_packet (rx_valid_packet),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_parity_err   (rd_parity_err),
    .empty           (empty),
    .full            (full),
    .count           (count),
    .overflow        (overflow),
    .overflow_clr    (overflow_clr),
    .parity_err_cnt  (parity_err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected pops: {parity_err, data}.
  logic [8:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: DUT presented 0x%0h with nothing expected", rd_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("pop_data", 32'(rd_data), 32'(e[7:0]));
        check("pop_perr", 32'(rd_parity_err), 32'(e[8]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick(3);
    rst = 1'b0;
  endtask

  // One receiver frame with a 16-clk baud: write_en low, then rise with the
  // byte stable. The push cycle is the 2nd edge after the rise; pop_in_push
  // raises rd_en exactly for that cycle.
  task automatic send_frame(input logic [7:0] d, input logic v, input bit accept, input bit pop_in_push);
    rx_write_en = 1'b0;
    tick(8);
    rx_data         = d;
    rx_valid_packet = v;
    if (accept) exp_q.push_back({~v, d});
    rx_write_en = 1'b1;
    tick(2);
    if (pop_in_push) rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(5);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    rst             = 1'b1;
    rx_write_en     = 1'b1;
    rx_data         = 8'h00;
    rx_valid_packet = 1'b1;
    rd_en           = 1'b0;
    overflow_clr    = 1'b0;
    do_reset();

    // Reset state
    check("rst_empty",    32'(empty), 32'd1);
    check("rst_full",     32'(full), 32'd0);
    check("rst_count",    32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_perr_cnt", 32'(parity_err_cnt), 32'd0);
    check("rst_rd_data",  32'(rd_data), 32'd0);
    check("rst_rd_perr",  32'(rd_parity_err), 32'd0);

    // 1. Single frame and latency
    rx_write_en = 1'b0;
    tick(8);
    rx_data         = 8'hA5;
    rx_valid_packet = 1'b1;
    exp_q.push_back({1'b0, 8'hA5});
    rx_write_en = 1'b1;
    lat = 0;
    while (empty && lat < 4) begin
      tick(1);
      lat++;
    end
    check("t1_empty_fall", 32'(empty), 32'd0);
    check("t1_rd_data",    32'(rd_data), 32'hA5);
    check("t1_rd_perr",    32'(rd_parity_err), 32'd0);
    tick(2);
    check("t1_count",      32'(count), 32'd1);
    pop_one();
    check("t1_empty_after_pop", 32'(empty), 32'd1);
    check("t1_rd_data_empty",   32'(rd_data), 32'd0);

    // 2. Reset immunity with write_en held high
    rx_write_en = 1'b1;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("t2_count_idle", 32'(count), 32'd0);
    end

    // 3. Fill and overflow
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, i <= DEPTH, 1'b0);
    end
    check("t3_full",     32'(full), 32'd1);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_count",    32'(count), 32'd8);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("t3_overflow_clr", 32'(overflow), 32'd0);
    repeat (DEPTH) pop_one();
    check("t3_drained_empty", 32'(empty), 32'd1);
    check("t3_scoreboard_left", 32'(exp_q.size()), 32'd0);

    // 4. Full plus simultaneous pop
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h20 + 8'(i), 1'b1, 1'b1, 1'b0);
    end
    check("t4_full", 32'(full), 32'd1);
    send_frame(8'h10, 1'b1, 1'b1, 1'b1);
    check("t4_count",    32'(count), 32'd8);
    check("t4_overflow", 32'(overflow), 32'd0);
    repeat (DEPTH) pop_one();
    check("t4_drained_empty", 32'(empty), 32'd1);
    check("t4_scoreboard_left", 32'(exp_q.size()), 32'd0);

    // 5. Parity error flag and counter saturation
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check("t5_head_perr", 32'(rd_parity_err), 32'd1);
    check("t5_head_data", 32'(rd_data), 32'h3C);
    check("t5_perr_cnt1", 32'(parity_err_cnt), 32'd1);
    pop_one();
    for (int i = 0; i < 300; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, 1'b0);
      pop_one();
    end
    check("t5_perr_cnt_sat", 32'(parity_err_cnt), 32'd255);
    check("t5_empty", 32'(empty), 32'd1);

    // 6. Pointer wrap with data in order, then reset with entries queued
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h40 + 8'(i), 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      send_frame(8'h50 + 8'(i), 1'b1, 1'b1, 1'b0);
      pop_one();
    end
    check("t6_count_before_rst", 32'(count), 32'd3);
    check("t6_perr_before_rst",  32'(parity_err_cnt), 32'd255);
    do_reset();
    check("t6_count",    32'(count), 32'd0);
    check("t6_empty",    32'(empty), 32'd1);
    check("t6_full",     32'(full), 32'd0);
    check("t6_perr_cnt", 32'(parity_err_cnt), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_rd_data",  32'(rd_data), 32'd0);
    tick(10);
    check("t6_no_false_push", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
